// File: rtl/uart_rx_sampler.sv
// UART receive front-end: pin synchroniser, oversample tick, start qualification,
// 3-sample majority vote at mid-bit and per-bit strobes with frame status.
module uart_rx_sampler #(
  parameter int unsigned OSR       = 16,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_bit,
  input  logic        rx_en,
  input  logic [15:0] baud_rate,
  input  logic        parity_enable,
  input  logic        stop_bit,
  output logic        rx_sample,
  output logic        rx_sample_valid,
  output logic [3:0]  rx_bit_index,
  output logic        rx_frame_start,
  output logic        rx_frame_done,
  output logic        stop_bit_error,
  output logic        noise_flag,
  output logic        break_detect
);

  localparam int unsigned OS_W  = $clog2(OSR);
  localparam int unsigned IDX_W = 4;
  localparam int unsigned DIV_W = 16;

  localparam logic [OS_W-1:0]  VOTE0     = OS_W'(OSR / 2 - 1);
  localparam logic [OS_W-1:0]  VOTE1     = OS_W'(OSR / 2);
  localparam logic [OS_W-1:0]  VOTE2     = OS_W'(OSR / 2 + 1);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t             state_q, state_d;
  logic               sync1_q, sync2_q, hist_q;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [OS_W-1:0]    os_q, os_d;
  logic               s0_q, s0_d, s1_q, s1_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               stop_cnt_q, stop_cnt_d;
  logic               noise_acc_q, noise_acc_d;
  logic               err_acc_q, err_acc_d;
  logic               zero_acc_q, zero_acc_d;
  logic               sample_q, sample_d;
  logic               valid_q, valid_d;
  logic [IDX_W-1:0]   index_q, index_d;
  logic               start_q, start_d;
  logic               done_q, done_d;
  logic               serr_q, serr_d;
  logic               noise_q, noise_d;
  logic               brk_q, brk_d;

  logic               rx_s, fall, tick, vote_tick, maj, dis, in_frame;
  logic [DIV_W-1:0]   reload;

  // A divisor of 0 behaves like 1: tick every clock.
  assign reload    = (baud_rate == 16'd0) ? 16'd0 : baud_rate - 16'd1;
  assign rx_s      = sync2_q;
  assign fall      = hist_q & ~sync2_q;
  assign tick      = (div_q == '0);
  assign vote_tick = tick && (os_q == VOTE2);
  assign maj       = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
  assign dis       = ~((s0_q == s1_q) && (s1_q == rx_s));
  assign in_frame  = (state_q == S_DATA) || (state_q == S_PARITY) || (state_q == S_STOP);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      hist_q      <= 1'b1;
      div_q       <= '0;
      os_q        <= '0;
      s0_q        <= 1'b0;
      s1_q        <= 1'b0;
      idx_q       <= '0;
      stop_cnt_q  <= 1'b0;
      noise_acc_q <= 1'b0;
      err_acc_q   <= 1'b0;
      zero_acc_q  <= 1'b0;
      sample_q    <= 1'b0;
      valid_q     <= 1'b0;
      index_q     <= '0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      serr_q      <= 1'b0;
      noise_q     <= 1'b0;
      brk_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= rx_bit;
      sync2_q     <= sync1_q;
      hist_q      <= sync2_q;
      div_q       <= div_d;
      os_q        <= os_d;
      s0_q        <= s0_d;
      s1_q        <= s1_d;
      idx_q       <= idx_d;
      stop_cnt_q  <= stop_cnt_d;
      noise_acc_q <= noise_acc_d;
      err_acc_q   <= err_acc_d;
      zero_acc_q  <= zero_acc_d;
      sample_q    <= sample_d;
      valid_q     <= valid_d;
      index_q     <= index_d;
      start_q     <= start_d;
      done_q      <= done_d;
      serr_q      <= serr_d;
      noise_q     <= noise_d;
      brk_q       <= brk_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    div_d       = tick ? reload : div_q - 16'd1;
    os_d        = tick ? os_q + OS_W'(1) : os_q;
    s0_d        = (tick && (os_q == VOTE0)) ? rx_s : s0_q;
    s1_d        = (tick && (os_q == VOTE1)) ? rx_s : s1_q;
    idx_d       = idx_q;
    stop_cnt_d  = stop_cnt_q;
    noise_acc_d = noise_acc_q;
    err_acc_d   = err_acc_q;
    zero_acc_d  = zero_acc_q;
    sample_d    = sample_q;
    index_d     = index_q;
    valid_d     = 1'b0;
    start_d     = 1'b0;
    done_d      = 1'b0;
    serr_d      = 1'b0;
    noise_d     = 1'b0;
    brk_d       = 1'b0;

    // Every data, parity and stop vote produces a strobe and feeds the accumulators.
    if (vote_tick && in_frame) begin
      valid_d     = 1'b1;
      sample_d    = maj;
      index_d     = idx_q;
      idx_d       = idx_q + IDX_W'(1);
      noise_acc_d = noise_acc_q | dis;
      zero_acc_d  = zero_acc_q & ~maj;
    end

    case (state_q)
      S_IDLE: begin
        if (fall) begin
          state_d = S_START;
          div_d   = reload;
          os_d    = '0;
        end
      end
      S_START: begin
        if (vote_tick) begin
          if (maj) begin
            state_d = S_IDLE;
          end else begin
            start_d     = 1'b1;
            noise_acc_d = 1'b0;
            err_acc_d   = 1'b0;
            zero_acc_d  = 1'b1;
            idx_d       = '0;
            state_d     = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (vote_tick && (idx_q == LAST_DATA)) begin
          stop_cnt_d = 1'b0;
          state_d    = parity_enable ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (vote_tick) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (vote_tick) begin
          err_acc_d = err_acc_q | ~maj;
          if (stop_cnt_q == stop_bit) begin
            done_d  = 1'b1;
            serr_d  = err_acc_q | ~maj;
            noise_d = noise_acc_q | dis;
            brk_d   = zero_acc_q & ~maj;
            // A low final stop means a held line; wait for it to go high first.
            state_d = maj ? S_IDLE : S_WAIT_HIGH;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      S_WAIT_HIGH: begin
        if (tick && rx_s) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (!rx_en) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      start_d = 1'b0;
      done_d  = 1'b0;
      serr_d  = 1'b0;
      noise_d = 1'b0;
      brk_d   = 1'b0;
    end
  end

  assign rx_sample       = sample_q;
  assign rx_sample_valid = valid_q;
  assign rx_bit_index    = index_q;
  assign rx_frame_start  = start_q;
  assign rx_frame_done   = done_q;
  assign stop_bit_error  = serr_q;
  assign noise_flag      = noise_q;
  assign break_detect    = brk_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler: logs strobes/frame events and checks them
// against hand-derived frame timing (baud_rate=4, 64 clocks per bit).
module tb_uart_rx_sampler;

  logic        clock = 1'b0;
  logic        reset;
  logic        rx_bit;
  logic        rx_en;
  logic [15:0] baud_rate;
  logic        parity_enable;
  logic        stop_bit;
  logic        rx_sample;
  logic        rx_sample_valid;
  logic [3:0]  rx_bit_index;
  logic        rx_frame_start;
  logic        rx_frame_done;
  logic        stop_bit_error;
  logic        noise_flag;
  logic        break_detect;

  uart_rx_sampler dut (
    .clock          (clock),
    .reset          (reset),
    .rx_bit         (rx_bit),
    .rx_en          (rx_en),
    .baud_rate      (baud_rate),
    .parity_enable  (parity_enable),
    .stop_bit       (stop_bit),
    .rx_sample      (rx_sample),
    .rx_sample_valid(rx_sample_valid),
    .rx_bit_index   (rx_bit_index),
    .rx_frame_start (rx_frame_start),
    .rx_frame_done  (rx_frame_done),
    .stop_bit_error (stop_bit_error),
    .noise_flag     (noise_flag),
    .break_detect   (break_detect)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] idx;
    logic       s;
  } strb_t;

  typedef struct {
    int   cyc;
    logic err;
    logic noise;
    logic brk;
  } done_t;

  strb_t strb_q[$];
  done_t done_q[$];
  int    start_q[$];

  // Event log, sampled on the falling edge away from the active edge.
  always @(negedge clock) begin
    if (rx_sample_valid === 1'b1) strb_q.push_back('{cyc, rx_bit_index, rx_sample});
    if (rx_frame_done === 1'b1) done_q.push_back('{cyc, stop_bit_error, noise_flag, break_detect});
    if (rx_frame_start === 1'b1) start_q.push_back(cyc);
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_logs();
    strb_q.delete();
    done_q.delete();
    start_q.delete();
  endtask

  task automatic hold(input logic v, input int n);
    rx_bit = v;
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Drives one frame; glitch_bit selects a frame bit whose first vote sample is inverted.
  task automatic send_frame(input logic [7:0] data, input logic par_en, input logic par,
                            input int nstop, input logic stop_val, input int glitch_bit,
                            output int t0);
    logic fb [12];
    int   nb;
    t0    = cyc;
    fb[0] = 1'b0;
    for (int i = 0; i < 8; i++) fb[i+1] = data[i];
    nb = 9;
    if (par_en) begin
      fb[nb] = par;
      nb++;
    end
    for (int i = 0; i < nstop; i++) begin
      fb[nb] = stop_val;
      nb++;
    end
    for (int j = 0; j < nb; j++) begin
      if (j == glitch_bit) begin
        hold(fb[j], 30);
        hold(~fb[j], 4);
        hold(fb[j], 30);
      end else begin
        hold(fb[j], 64);
      end
    end
  endtask

  // Frame bit j is voted from pin samples near clocks t0+64j+33..41; outputs appear at t0+64j+43.
  task automatic verify(input string tag, input int t0, input logic [7:0] data,
                        input logic par_en, input logic par, input int nstop,
                        input logic stop_val, input logic e_err, input logic e_noise,
                        input logic e_brk);
    int   nstrb;
    logic es;
    nstrb = 8 + (par_en ? 1 : 0) + nstop;
    check({tag, "_nstart"}, 32'(start_q.size()), 32'd1);
    if (start_q.size() > 0) check({tag, "_start_cyc"}, 32'(start_q[0]), 32'(t0 + 43));
    check({tag, "_nstrobe"}, 32'(strb_q.size()), 32'(nstrb));
    for (int k = 0; k < nstrb && k < strb_q.size(); k++) begin
      if (k < 8) es = data[k];
      else if (par_en && k == 8) es = par;
      else es = stop_val;
      check($sformatf("%s_idx%0d", tag, k), 32'(strb_q[k].idx), 32'(k));
      check($sformatf("%s_bit%0d", tag, k), 32'(strb_q[k].s), 32'(es));
      check($sformatf("%s_cyc%0d", tag, k), 32'(strb_q[k].cyc), 32'(t0 + 64 * (k + 1) + 43));
    end
    check({tag, "_ndone"}, 32'(done_q.size()), 32'd1);
    if (done_q.size() > 0) begin
      check({tag, "_done_cyc"}, 32'(done_q[0].cyc), 32'(t0 + 64 * nstrb + 43));
      check({tag, "_stop_err"}, 32'(done_q[0].err), 32'(e_err));
      check({tag, "_noise"}, 32'(done_q[0].noise), 32'(e_noise));
      check({tag, "_break"}, 32'(done_q[0].brk), 32'(e_brk));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0;
    reset         = 1'b0;
    rx_bit        = 1'b1;
    rx_en         = 1'b0;
    baud_rate     = 16'd4;
    parity_enable = 1'b0;
    stop_bit      = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_outs",
          32'({rx_sample, rx_sample_valid, rx_bit_index, rx_frame_start, rx_frame_done,
               stop_bit_error, noise_flag, break_detect}), 32'd0);
    reset = 1'b1;
    rx_en = 1'b1;
    hold(1'b1, 100);

    // T1: 8N1 0xA5, clean
    clear_logs();
    send_frame(8'hA5, 1'b0, 1'b0, 1, 1'b1, -1, t0);
    hold(1'b1, 128);
    verify("t1", t0, 8'hA5, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b0);

    // T2: 8E2 0x3C, even parity 0
    parity_enable = 1'b1;
    stop_bit      = 1'b1;
    clear_logs();
    send_frame(8'h3C, 1'b1, 1'b0, 2, 1'b1, -1, t0);
    hold(1'b1, 128);
    verify("t2", t0, 8'h3C, 1'b1, 1'b0, 2, 1'b1, 1'b0, 1'b0, 1'b0);
    parity_enable = 1'b0;
    stop_bit      = 1'b0;

    // T3: 20-clock low glitch is a false start
    clear_logs();
    hold(1'b0, 20);
    hold(1'b1, 200);
    check("t3_nstart", 32'(start_q.size()), 32'd0);
    check("t3_nstrobe", 32'(strb_q.size()), 32'd0);
    check("t3_ndone", 32'(done_q.size()), 32'd0);

    // T4: 0x55 with stop bit driven low
    clear_logs();
    send_frame(8'h55, 1'b0, 1'b0, 1, 1'b0, -1, t0);
    hold(1'b1, 128);
    verify("t4", t0, 8'h55, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b0);

    // T5: line held low for three frame times, then a clean 0x81
    clear_logs();
    t0 = cyc;
    hold(1'b0, 1920);
    hold(1'b1, 128);
    verify("t5_brk", t0, 8'h00, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b1);
    clear_logs();
    send_frame(8'h81, 1'b0, 1'b0, 1, 1'b1, -1, t0);
    hold(1'b1, 128);
    verify("t5_rx", t0, 8'h81, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b0);

    // T6a: glitch on the first vote sample of data bit 2
    clear_logs();
    send_frame(8'h3C, 1'b0, 1'b0, 1, 1'b1, 3, t0);
    hold(1'b1, 128);
    verify("t6_noise", t0, 8'h3C, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b1, 1'b0);

    // T6b: rx_en dropped during data bit 1, raised again while the line is still low
    clear_logs();
    fork
      send_frame(8'h00, 1'b0, 1'b0, 1, 1'b1, -1, t0);
      begin
        repeat (138) @(posedge clock);
        #1;
        rx_en = 1'b0;
        repeat (256) @(posedge clock);
        rx_en = 1'b1;
      end
    join
    hold(1'b1, 128);
    check("t6_abort_nstart", 32'(start_q.size()), 32'd1);
    check("t6_abort_nstrobe", 32'(strb_q.size()), 32'd1);
    if (strb_q.size() > 0) check("t6_abort_cyc0", 32'(strb_q[0].cyc), 32'(t0 + 107));
    check("t6_abort_ndone", 32'(done_q.size()), 32'd0);
    clear_logs();
    send_frame(8'h81, 1'b0, 1'b0, 1, 1'b1, -1, t0);
    hold(1'b1, 128);
    verify("t6_rx", t0, 8'h81, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
